// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: control handshake and SPI pin bundle for spi_master_multi
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int CS_SEL_W = 2
);
  logic start;
  logic [1:0] mode;
  logic lsb_first;
  logic [CS_SEL_W-1:0] cs_sel;
  logic [DATA_W-1:0] data_tx;
  logic [DATA_W-1:0] data_rx;
  logic busy;
  logic done;
  logic sclk;
  logic mosi;
  logic miso;
  logic [NUM_CS-1:0] cs_n;
  modport master (
    input start, mode, lsb_first, cs_sel, data_tx, miso,
    output data_rx, busy, done, sclk, mosi, cs_n
  );
  modport slave (
    output start, mode, lsb_first, cs_sel, data_tx, miso,
    input data_rx, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with per-frame mode, bit order and one-hot chip select
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS = 4,
  parameter int CS_SEL_W = 2
) (
  input logic clk,
  input logic reset,
  spi_master_multi_if.master bus
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [CS_SEL_W-1:0] cs_l;
  logic cpha_l, lsb_l;
  logic accept, tick, lead, last, fin, drive, sample, busy_d, sclk_d, mosi_d;
  logic [NUM_CS-1:0] cs_n_d;
  assign accept = state == IDLE && bus.start;
  assign tick = div == DIV_W'(CLK_DIV - 1);
  assign lead = !cnt[0];
  assign last = cnt == CNT_W'(2 * DATA_W - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = accept ? SETUP
             : state == SETUP ? SHIFT
             : state == SHIFT && tick && last ? HOLD
             : state == HOLD && tick ? IDLE
             : state;
  end
  // Outputs are computed here and registered, so every pin lags the FSM by one cycle
  always_comb begin
    fin = state == HOLD && tick;
    busy_d = state != IDLE && !fin;
    drive = cpha_l ? state == SHIFT && tick && lead
                   : state == SETUP || (state == SHIFT && tick && !lead && !last);
    sample = state == SHIFT && tick && (cpha_l ? !lead : lead);
    sclk_d = state == IDLE ? bus.mode[1] : state == SHIFT && tick ? !bus.sclk : bus.sclk;
    mosi_d = drive ? (lsb_l ? tx_sh[0] : tx_sh[DATA_W-1]) : bus.mosi;
    cs_n_d = '1;
    for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = !(busy_d && cs_l == CS_SEL_W'(i));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div <= '0;
      cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      cs_l <= '0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      bus.data_rx <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sclk <= 1'b0;
      bus.mosi <= 1'b0;
      bus.cs_n <= '1;
    end else begin
      div <= (state == SHIFT || state == HOLD) && !tick ? div + 1'b1 : '0;
      cnt <= state == SHIFT ? cnt + CNT_W'(tick) : '0;
      tx_sh <= accept ? bus.data_tx : drive ? (lsb_l ? tx_sh >> 1 : tx_sh << 1) : tx_sh;
      rx_sh <= !sample ? rx_sh
             : lsb_l ? {bus.miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], bus.miso};
      if (accept) begin
        cs_l <= bus.cs_sel;
        cpha_l <= bus.mode[0];
        lsb_l <= bus.lsb_first;
      end
      if (fin) bus.data_rx <= rx_sh;
      bus.busy <= busy_d;
      bus.done <= fin;
      bus.sclk <= sclk_d;
      bus.mosi <= mosi_d;
      bus.cs_n <= cs_n_d;
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench with an SPI slave model for spi_master_multi
module tb_spi_master_multi;
  localparam int W = 8;
  localparam int D = 4;
  localparam int LAT = (2 * W + 1) * D + 1;
  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    logic [1:0] mode;
    logic lsb;
    logic [3:0] cs;
    time t0;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  item_t sb[$];
  item_t cur;
  logic pbusy = 1'b0;
  logic psclk = 1'b0;
  logic lead;
  logic [W-1:0] srx;
  int sidx, ridx, edges;
  always #5 clk = ~clk;
  spi_master_multi_if #(.DATA_W(W), .NUM_CS(4), .CS_SEL_W(2)) bus ();
  spi_master_multi #(.DATA_W(W), .CLK_DIV(D), .NUM_CS(4), .CS_SEL_W(2)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  spi_master_multi_if #(.DATA_W(W), .NUM_CS(3), .CS_SEL_W(2)) b3 ();
  spi_master_multi #(.DATA_W(W), .CLK_DIV(D), .NUM_CS(3), .CS_SEL_W(2)) dut3 (
    .clk(clk), .reset(rst), .bus(b3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int cyc_of(input time t0);
    return int'(($time - t0 - 5) / 10);
  endfunction
  function automatic logic sbit(input item_t it, input int i);
    return it.lsb ? it.rx[i] : it.rx[W-1-i];
  endfunction
  // Slave model and done monitor, both sampled on the falling edge
  always @(negedge clk) begin
    if (bus.busy && !pbusy) begin
      if (sb.size() == 0) check("frame_unexpected", 1, 0);
      else begin
        cur = sb[0];
        sidx = 0;
        ridx = 0;
        srx = '0;
        edges = 0;
        check("cs_n_first", 32'(bus.cs_n), 32'(cur.cs));
        check("busy_cycle", cyc_of(cur.t0), 1);
        if (!cur.mode[0]) begin
          bus.miso = sbit(cur, 0);
          sidx = 1;
        end
      end
    end else if (bus.busy && bus.sclk != psclk) begin
      edges++;
      lead = bus.sclk != cur.mode[1];
      if (lead != cur.mode[0]) begin
        if (ridx < W) srx[cur.lsb ? ridx : W-1-ridx] = bus.mosi;
        ridx++;
      end else if (sidx < W) begin
        bus.miso = sbit(cur, sidx);
        sidx++;
      end
    end
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        cur = sb.pop_front();
        check("done_cycle", cyc_of(cur.t0), LAT);
        check("data_rx", 32'(bus.data_rx), 32'(cur.rx));
        check("slave_rx", 32'(srx), 32'(cur.tx));
        check("sclk_edges", edges, 2 * W);
        check("sclk_end", 32'(bus.sclk), 32'(cur.mode[1]));
        check("cs_n_done", 32'(bus.cs_n), 32'hF);
        check("busy_done", 32'(bus.busy), 0);
      end
    end
    pbusy = bus.busy;
    psclk = bus.sclk;
  end
  task automatic push(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic [1:0] mode,
                      input logic lsb, input logic [1:0] sel);
    item_t it;
    it.tx = tx;
    it.rx = rx;
    it.mode = mode;
    it.lsb = lsb;
    it.cs = 4'(~(4'b0001 << sel));
    it.t0 = $time;
    sb.push_back(it);
  endtask
  task automatic drive(input logic [W-1:0] tx, input logic [1:0] mode, input logic lsb,
                       input logic [1:0] sel);
    bus.data_tx = tx;
    bus.mode = mode;
    bus.lsb_first = lsb;
    bus.cs_sel = sel;
    bus.start = 1'b1;
  endtask
  task automatic send(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic [1:0] mode,
                      input logic lsb, input logic [1:0] sel);
    @(negedge clk);
    drive(tx, mode, lsb, sel);
    @(posedge clk);
    push(tx, rx, mode, lsb, sel);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 0, 1);
      sb.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, d0;
    time t3;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.lsb_first = 1'b0;
    bus.cs_sel = '0;
    bus.data_tx = '0;
    bus.miso = 1'b0;
    b3.start = 1'b0;
    b3.mode = 2'b00;
    b3.lsb_first = 1'b0;
    b3.cs_sel = '0;
    b3.data_tx = '0;
    b3.miso = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sclk", 32'(bus.sclk), 0);
    check("rst_mosi", 32'(bus.mosi), 0);
    check("rst_cs_n", 32'(bus.cs_n), 32'hF);
    check("rst_data_rx", 32'(bus.data_rx), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hBD, 8'hE7, 2'b00, 1'b0, 2'd0);
    wait_idle();
    bus.mode = 2'b11;
    repeat (2) @(negedge clk);
    check("sclk_idle_cpol1", 32'(bus.sclk), 1);
    send(8'h6D, 8'hCE, 2'b11, 1'b1, 2'd2);
    wait_idle();
    send(8'hF0, 8'hD4, 2'b10, 1'b0, 2'd1);
    wait_idle();
    send(8'hF0, 8'hD4, 2'b01, 1'b0, 2'd3);
    wait_idle();
    d0 = n_done;
    send(8'h3C, 8'hA5, 2'b00, 1'b0, 2'd0);
    repeat (19) @(negedge clk);
    bus.data_tx = 8'hFF;
    bus.cs_sel = 2'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (80) @(negedge clk);
    check("single_done", n_done - d0, 1);
    @(negedge clk);
    drive(8'h12, 2'b00, 1'b0, 2'd1);
    @(posedge clk);
    push(8'h12, 8'h34, 2'b00, 1'b0, 2'd1);
    @(negedge clk);
    drive(8'h56, 2'b00, 1'b0, 2'd2);
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_done", 32'(bus.done), 1);
    @(posedge clk);
    push(8'h56, 8'h78, 2'b00, 1'b0, 2'd2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    send(8'h99, 8'h66, 2'b10, 1'b0, 2'd1);
    repeat (29) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(bus.cs_n), 32'hF);
    check("abort_sclk", 32'(bus.sclk), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_data_rx", 32'(bus.data_rx), 0);
    sb.delete();
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    send(8'h81, 8'h18, 2'b00, 1'b1, 2'd0);
    wait_idle();
    @(negedge clk);
    b3.data_tx = 8'h5A;
    b3.cs_sel = 2'd3;
    b3.start = 1'b1;
    @(posedge clk);
    t3 = $time;
    @(negedge clk);
    b3.start = 1'b0;
    n = 0;
    while (!b3.done && n < 200) begin
      if (cyc_of(t3) == 1 || cyc_of(t3) == 40) check("cs3_high", 32'(b3.cs_n), 32'h7);
      @(negedge clk);
      n++;
    end
    check("cs3_done_cycle", cyc_of(t3), LAT);
    check("cs3_cs_n_done", 32'(b3.cs_n), 32'h7);
    check("cs3_data_rx", 32'(b3.data_rx), 32'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised SPI master, next generation of the existing 8-bit single-slave master.
- Adds generic frame width, programmable SCLK divider, and multiple one-hot active-low chip selects.
- Adds per-transfer selection of SPI mode (CPOL/CPHA) and of bit order.
- Sits between the system-clock control logic and the SPI pins, driving one of NUM_CS slaves.

Parameters:
- DATA_W, 8, bits per frame (≥2).
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
- NUM_CS, 4, number of chip-select outputs (≥1).
- CS_SEL_W, 2, width of cs_sel (2^CS_SEL_W ≥ NUM_CS).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  transfer request, sampled only in IDLE.
- mode  in  2  [1]=CPOL, [0]=CPHA; latched at start.
- lsb_first  in  1  1 = LSB shifted first; latched at start.
- cs_sel  in  CS_SEL_W  slave index; latched at start.
- data_tx  in  DATA_W  frame to send; latched at start.
- data_rx  out  DATA_W  last received frame.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values (asserted immediately on reset, async):
  - data_rx=0, busy=0, done=0, sclk=0, mosi=0, cs_n=all ones.
  - Reset mid-transfer aborts the frame, with no done pulse.
- States and transitions:
  - IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - Cycle 0 is the edge where start=1 is sampled in IDLE.
- Timing with D=CLK_DIV, W=DATA_W:
  - Cycle 1: enter SETUP; busy=1, cs_n[cs_sel]=0.
  - SCLK edges at cycles 1+k·D, k=1..2W; odd k = leading edge, even k = trailing edge.
  - Cycle 1+(2W+1)·D: cs_n all high, busy=0, done=1 for exactly that cycle, data_rx updated that cycle.
  - Start-to-done latency: (2W+1)·D+1 cycles; W=8, D=4 -> 69.
- SCLK:
  - Idle level = CPOL.
  - In IDLE, sclk tracks mode[1], registered one cycle.
  - Each of the 2W edges toggles sclk; sclk ends at CPOL.
- CPHA=0:
  - First bit driven on mosi at cycle 1.
  - miso sampled on leading edges; next bit driven on trailing edges, except the last trailing edge.
- CPHA=1:
  - mosi driven on leading edges; miso sampled on trailing edges.
- Bit order:
  - lsb_first=0: bit W-1 first; received bits shift in at LSB, so the first received bit lands in bit W-1.
  - lsb_first=1: mirror of the above, bit 0 first.
- mosi holds its last driven bit until the next transfer.
- Input handling:
  - start while busy, or in HOLD, is ignored.
  - start in the done cycle is accepted, giving back-to-back frames.
  - cs_sel ≥ NUM_CS: the frame runs normally, but all cs_n stay high; data_rx and done still update.
  - Changes to mode, data_tx or cs_sel after cycle 0 have no effect on the frame in progress.
  - data_rx holds its value until the next done.

Test Plan:
- W=8, D=4, mode 00, MSB-first, cs_sel=0; data_tx=0xBD; loopback slave returns 0xE7:
  - cs_n=1110 from cycle 1; done pulse at cycle 69; data_rx=0xE7.
  - Slave receives 0xBD; exactly 16 sclk edges.
- Mode 11, lsb_first=1, cs_sel=2; data_tx=0x6D; slave returns 0xCE:
  - sclk idles 1; cs_n=1011; mosi bit sequence 1,0,1,1,0,1,1,0.
  - data_rx=0xCE; slave sees 0x6D.
- Mode 10 and mode 01, data_tx=0xF0, slave returns 0xD4:
  - Samples occur on the correct edge per CPHA; data_rx=0xD4 in both modes.
- start pulsed again at cycle 20 of a frame:
  - Ignored; single done at cycle 69.
- start held high through the done cycle:
  - Second frame begins cycle 70; cs_n low again at cycle 71.
- reset at cycle 30 of a frame:
  - Same cycle: cs_n=1111, sclk=0, busy=0, data_rx=0; no done pulse.
- cs_sel=3 with NUM_CS=3:
  - cs_n stays 111; done at cycle 69.
